// File: rtl/nibble_sequencer.sv
// rtl/nibble_sequencer.sv - fetch/execute control stage for the 4-bit processor
//
// Fetches instruction bytes from the program ROM, decodes them, drives the
// ALU operand/function inputs and registers the ALU result into the
// accumulator and the carry/zero flags. Also provides a 4-bit input port,
// a 4-bit output port and conditional jumps on the registered flags.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   enable              low freezes all state and forces out_we to 0
//   program_byte        ROM data at address pc ([7:4] opcode, [3:0] operand)
//   pc                  program counter / ROM address
//   alu_a/alu_b/alu_f   ALU operands and function code
//   alu_s/alu_c/alu_z   ALU result, carry/borrow and zero
//   accu, flag_c/flag_z accumulator and registered flags
//   data_in, data_out   input port, output port register
//   out_we              one-cycle strobe after data_out is updated
//   phase, halted       current state encoding, high in HALTED

module nibble_sequencer #(
  parameter int PC_WIDTH = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          program_byte,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [3:0]          alu_f,
  input  logic [3:0]          alu_s,
  input  logic                alu_c,
  input  logic                alu_z,
  output logic [3:0]          accu,
  output logic                flag_c,
  output logic                flag_z,
  input  logic [3:0]          data_in,
  output logic [3:0]          data_out,
  output logic                out_we,
  output logic [1:0]          phase,
  output logic                halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    ADDR   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_OUT   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JC    = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JNC   = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_PASS = 4'b0010;
  localparam logic [3:0] F_ADD  = 4'b0011;
  localparam logic [3:0] F_NAND = 4'b0100;

  state_t              state, state_n;
  logic [7:0]          ir, ir_n;
  logic [PC_WIDTH-1:0] pc_n;
  logic [3:0]          accu_n;
  logic                flag_c_n, flag_z_n;
  logic [3:0]          data_out_n;
  logic                out_we_q, out_we_n;
  logic                take;
  logic [3:0]          opcode, operand;

  assign opcode  = ir[7:4];
  assign operand = ir[3:0];
  assign alu_a   = accu;
  assign phase   = state;
  assign halted  = (state == HALTED);
  // Masked so the strobe drops immediately when enable falls.
  assign out_we  = out_we_q & enable;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    accu_n     = accu;
    flag_c_n   = flag_c;
    flag_z_n   = flag_z;
    data_out_n = data_out;
    out_we_n   = 1'b0;
    alu_f      = F_NONE;
    alu_b      = 4'h0;
    take       = 1'b0;

    unique case (state)
      FETCH: begin
        ir_n    = program_byte;
        pc_n    = pc + PC_WIDTH'(1);
        state_n = EXEC;
      end

      EXEC: begin
        state_n = FETCH;
        case (opcode)
          OP_LIT, OP_ADDI, OP_SUBI, OP_NANDI, OP_IN: begin
            unique case (opcode)
              OP_LIT:  alu_f = F_PASS;
              OP_ADDI: alu_f = F_ADD;
              OP_SUBI: alu_f = F_SUB;
              OP_IN:   alu_f = F_PASS;
              default: alu_f = F_NAND;
            endcase
            alu_b    = (opcode == OP_IN) ? data_in : operand;
            accu_n   = alu_s;
            flag_c_n = alu_c;
            flag_z_n = alu_z;
          end
          OP_CMPI: begin
            alu_f    = F_SUB;
            alu_b    = operand;
            flag_c_n = alu_c;
            flag_z_n = alu_z;
          end
          OP_OUT: begin
            data_out_n = accu;
            out_we_n   = 1'b1;
          end
          OP_JMP, OP_JC, OP_JZ, OP_JNC, OP_JNZ: state_n = ADDR;
          OP_HALT:                              state_n = HALTED;
          default: ;
        endcase
      end

      ADDR: begin
        // Flags here are the registered values left by earlier instructions.
        case (opcode)
          OP_JMP:  take = 1'b1;
          OP_JC:   take = flag_c;
          OP_JZ:   take = flag_z;
          OP_JNC:  take = ~flag_c;
          OP_JNZ:  take = ~flag_z;
          default: take = 1'b0;
        endcase
        // Not taken still consumes the address byte under pc.
        pc_n    = take ? PC_WIDTH'({operand, program_byte}) : pc + PC_WIDTH'(1);
        state_n = FETCH;
      end

      HALTED: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= 8'h00;
      accu     <= 4'h0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      data_out <= 4'h0;
      out_we_q <= 1'b0;
    end else if (enable) begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      accu     <= accu_n;
      flag_c   <= flag_c_n;
      flag_z   <= flag_z_n;
      data_out <= data_out_n;
      out_we_q <= out_we_n;
    end else begin
      out_we_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_sequencer.sv
// tb/tb_nibble_sequencer.sv - self-checking bench for nibble_sequencer

module tb_nibble_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  program_byte;
  logic [11:0] pc;
  logic [3:0]  alu_a, alu_b, alu_f, alu_s;
  logic        alu_c, alu_z;
  logic [3:0]  accu;
  logic        flag_c, flag_z;
  logic [3:0]  data_in = 4'h0;
  logic [3:0]  data_out;
  logic        out_we;
  logic [1:0]  phase;
  logic        halted;

  logic [3:0]  pc4;
  logic [3:0]  alu_a4, alu_b4, alu_f4, accu4, data_out4;
  logic        flag_c4, flag_z4, out_we4, halted4;
  logic [1:0]  phase4;

  logic [7:0]  rom [4096];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign program_byte = rom[pc];

  // ALU environment
  always_comb begin
    alu_s = 4'h0;
    alu_c = 1'b0;
    case (alu_f)
      4'b0001: {alu_c, alu_s} = {(alu_a < alu_b), 4'(alu_a - alu_b)};
      4'b0010: alu_s = alu_b;
      4'b0011: {alu_c, alu_s} = 5'(alu_a) + 5'(alu_b);
      4'b0100: alu_s = ~(alu_a & alu_b);
      default: ;
    endcase
    alu_z = (alu_s == 4'h0);
  end

  nibble_sequencer #(.PC_WIDTH(12)) dut (
    .clock(clock), .reset(reset), .enable(enable), .program_byte(program_byte),
    .pc(pc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s),
    .alu_c(alu_c), .alu_z(alu_z), .accu(accu), .flag_c(flag_c), .flag_z(flag_z),
    .data_in(data_in), .data_out(data_out), .out_we(out_we), .phase(phase),
    .halted(halted)
  );

  nibble_sequencer #(.PC_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .program_byte(8'h00),
    .pc(pc4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_f(alu_f4), .alu_s(4'h0),
    .alu_c(1'b0), .alu_z(1'b1), .accu(accu4), .flag_c(flag_c4), .flag_z(flag_z4),
    .data_in(4'h0), .data_out(data_out4), .out_we(out_we4), .phase(phase4),
    .halted(halted4)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic load(input logic [47:0] prog);
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    for (int k = 0; k < 6; k++) rom[k] = prog[47-8*k -: 8];
  endtask

  typedef struct {
    logic [47:0] prog;
    int          cyc;
    logic [3:0]  din;
    int          pc;
    int          acc;
    int          c;
    int          z;
    int          dout;
    int          ph;
  } vec_t;

  vec_t vecs[$];

  // Instruction-level reference model
  int         m_pc, m_acc, m_c, m_z, m_dout, m_owe;

  task automatic ref_step(input int din, output int cyc);
    int op, opd, t, take;
    op    = rom[m_pc] >> 4;
    opd   = rom[m_pc] & 15;
    m_pc  = (m_pc + 1) % 4096;
    m_owe = 0;
    cyc   = 2;
    case (op)
      1, 6: begin
        m_acc = (op == 6) ? din : opd;
        m_c = 0; m_z = (m_acc == 0);
      end
      2: begin
        t = m_acc + opd;
        m_acc = t % 16; m_c = t / 16; m_z = (m_acc == 0);
      end
      3, 5: begin
        t = m_acc - opd;
        m_c = (t < 0); m_z = (t == 0);
        if (op == 3) m_acc = (t + 16) % 16;
      end
      4: begin
        m_acc = 15 - (m_acc & opd);
        m_c = 0; m_z = (m_acc == 0);
      end
      7: begin
        m_dout = m_acc; m_owe = 1;
      end
      8, 9, 10, 11, 12: begin
        cyc  = 3;
        take = (op == 8) || (op == 9 && m_c == 1) || (op == 10 && m_z == 1) ||
               (op == 11 && m_c == 0) || (op == 12 && m_z == 0);
        if (take) m_pc = opd * 256 + rom[m_pc];
        else      m_pc = (m_pc + 1) % 4096;
      end
      default: ;
    endcase
  endtask

  initial begin
    int cyc, din;

    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    step(1);
    chk("reset_pc", pc, 0);
    chk("reset_phase", phase, 0);
    chk("reset_accu", accu, 0);
    chk("reset_flags", {flag_c, flag_z}, 0);
    chk("reset_dout", data_out, 0);
    chk("reset_owe", out_we, 0);
    chk("reset_halted", halted, 0);

    //                 program          cyc din  pc     acc  c  z  dout ph
    vecs.push_back(vec_t'{48'h152C70000000, 6, 4'h0, 3,     1,   1, 0, 1,  0});
    vecs.push_back(vec_t'{48'h1353A010F000, 7, 4'h0, 'h010, 3,   0, 1, 0,  0});
    vecs.push_back(vec_t'{48'h11C008F00000, 5, 4'h0, 8,     1,   0, 0, 0,  0});
    vecs.push_back(vec_t'{48'h10C008F00000, 5, 4'h0, 3,     0,   0, 1, 0,  0});
    vecs.push_back(vec_t'{48'hF00000000000, 2, 4'h0, 1,     0,   0, 0, 0,  3});
    vecs.push_back(vec_t'{48'h134400000000, 4, 4'h0, 2,     'hF, 0, 0, 0,  0});
    vecs.push_back(vec_t'{48'h123500000000, 4, 4'h0, 2,     'hD, 1, 0, 0,  0});
    vecs.push_back(vec_t'{48'h800500000000, 3, 4'h0, 5,     0,   0, 0, 0,  0});
    vecs.push_back(vec_t'{48'h9FFF00000000, 3, 4'h0, 2,     0,   0, 0, 0,  0});
    vecs.push_back(vec_t'{48'h1F2F91230000, 7, 4'h0, 'h123, 'hE, 1, 0, 0,  0});
    vecs.push_back(vec_t'{48'h106000000000, 4, 4'hA, 2,     'hA, 0, 0, 0,  0});

    foreach (vecs[i]) begin
      load(vecs[i].prog);
      data_in = vecs[i].din;
      do_reset();
      step(vecs[i].cyc);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_accu", i), accu, vecs[i].acc);
      chk($sformatf("vec%0d_c", i), flag_c, vecs[i].c);
      chk($sformatf("vec%0d_z", i), flag_z, vecs[i].z);
      chk($sformatf("vec%0d_dout", i), data_out, vecs[i].dout);
      chk($sformatf("vec%0d_phase", i), phase, vecs[i].ph);
    end

    // OUT strobe lasts exactly one cycle
    load(48'h152C70000000);
    do_reset();
    step(5);
    chk("owe_before", out_we, 0);
    step(1);
    chk("owe_pulse", out_we, 1);
    chk("owe_dout", data_out, 1);
    step(1);
    chk("owe_after", out_we, 0);

    // HALT holds until reset
    load(48'hF00000000000);
    do_reset();
    step(2);
    chk("halt_flag", halted, 1);
    chk("halt_phase", phase, 3);
    step(20);
    chk("halt_pc_hold", pc, 1);
    chk("halt_accu_hold", accu, 0);
    chk("halt_still", halted, 1);
    reset = 1'b1;
    #1;
    chk("halt_async_pc", pc, 0);
    chk("halt_async_halted", halted, 0);
    step(1);
    reset = 1'b0;

    // enable low during EXEC of ADDI
    load(48'h152C70000000);
    do_reset();
    step(3);
    chk("en_in_exec", phase, 1);
    enable = 1'b0;
    step(5);
    chk("en_frozen_pc", pc, 2);
    chk("en_frozen_accu", accu, 5);
    chk("en_frozen_phase", phase, 1);
    chk("en_frozen_owe", out_we, 0);
    enable = 1'b1;
    step(3);
    chk("en_resume_accu", accu, 1);
    chk("en_resume_c", flag_c, 1);
    chk("en_resume_pc", pc, 3);
    chk("en_resume_owe", out_we, 1);
    enable = 1'b0;
    #1;
    chk("en_mask_owe", out_we, 0);
    step(2);
    enable = 1'b1;
    step(1);

    // reset during ADDR of JMP
    load(48'h177080050000);
    do_reset();
    step(6);
    chk("rst_in_addr", phase, 2);
    chk("rst_pre_dout", data_out, 7);
    reset = 1'b1;
    #1;
    chk("rst_async_pc", pc, 0);
    chk("rst_async_accu", accu, 0);
    chk("rst_async_dout", data_out, 0);
    chk("rst_async_phase", phase, 0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("rst_no_jump_pc", pc, 1);
    chk("rst_no_jump_phase", phase, 1);

    // 4-bit pc wraps
    do_reset();
    step(30);
    chk("wrap_pc_f", pc4, 'hF);
    step(1);
    chk("wrap_pc_0", pc4, 0);

    // Random programs against the reference model
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'($urandom);
      if (rom[i][7:4] == 4'hF) rom[i][7:4] = 4'h7;
    end
    do_reset();
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_dout = 0; m_owe = 0;
    for (int n = 0; n < 400; n++) begin
      din = int'($urandom_range(0, 15));
      data_in = 4'(din);
      ref_step(din, cyc);
      if ($urandom_range(0, 7) == 0) begin
        step(1);
        enable = 1'b0;
        step(int'($urandom_range(1, 4)));
        enable = 1'b1;
        step(cyc - 1);
      end else begin
        step(cyc);
      end
      chk($sformatf("rnd%0d_pc", n), pc, m_pc);
      chk($sformatf("rnd%0d_accu", n), accu, m_acc);
      chk($sformatf("rnd%0d_c", n), flag_c, m_c);
      chk($sformatf("rnd%0d_z", n), flag_z, m_z);
      chk($sformatf("rnd%0d_dout", n), data_out, m_dout);
      chk($sformatf("rnd%0d_owe", n), out_we, m_owe);
      if (bad > 20) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
